// File: rtl/sobel_scan_ctrl_if.sv
// Bundles the controller's bus-side signals into one interface.
//   Pixel memory : mem_rd, mem_addr (out); mem_rdata (in, one cycle after mem_rd)
//   Detector     : z1..z6 window (out); z_out result (in, combinational from z1..z6)
//   Result stream: pix_data, pix_valid, pix_last (out); pix_ready (in)
// master = sobel_scan_ctrl, slave = memory/detector/writer side.
interface sobel_scan_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        z1, z2, z3, z4, z5, z6;
    logic [7:0]        z_out;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    modport master (
        output mem_rd, mem_addr, z1, z2, z3, z4, z5, z6, pix_data, pix_valid, pix_last,
        input  mem_rdata, z_out, pix_ready
    );

    modport slave (
        input  mem_rd, mem_addr, z1, z2, z3, z4, z5, z6, pix_data, pix_valid, pix_last,
        output mem_rdata, z_out, pix_ready
    );
endinterface

// File: rtl/sobel_scan_ctrl.sv
// Frame sequencer for the sobel3x3det datapath. Walks a ROWS x COLS image in a
// synchronous-read pixel memory, builds the six-pixel window for every interior
// pixel, captures the detector result and streams one pixel per position in
// raster order. Border pixels are emitted as 0.
// Ports:
//   clk   - system clock (rising edge)
//   reset - asynchronous active-low reset
//   start - begin a frame (sampled only in IDLE)
//   busy  - frame in progress
//   done  - one-cycle pulse after the last pixel handshake
//   bus   - memory / detector window / result stream (sobel_scan_ctrl_if.master)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start
// BORDER   | border pixel 0 presented, waiting for handshake
// PRIME    | four reads of cols 0,1 (rows r-1, r+1) at interior row entry
// FETCH_T  | read (r-1, c+1) on the bus
// FETCH_B  | read (r+1, c+1) on the bus
// SETTLE   | wait for bottom return + shift, then capture z_out
// OUT      | interior result presented, waiting for handshake
// DONE     | done pulse, back to IDLE
module sobel_scan_ctrl #(
    parameter int ROWS   = 436,
    parameter int COLS   = 576,
    parameter int ADDR_W = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    sobel_scan_ctrl_if.master  bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0]     ROW_ONE  = RW'(1);
    localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
    localparam logic [CW-1:0]     COL_ONE  = CW'(1);
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_COLS   = ADDR_W'(COLS);

    typedef enum logic [2:0] {
        S_IDLE, S_BORDER, S_PRIME, S_FETCH_T, S_FETCH_B, S_SETTLE, S_OUT, S_DONE
    } state_t;

    state_t            r_state;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [1:0]        r_pcnt;
    logic              r_mem_rd;
    logic              r_rd_top;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_ret_top;
    logic              r_ret_bot;
    logic [7:0]        r_stage;
    logic [7:0]        r_z1, r_z2, r_z3, r_z4, r_z5, r_z6;
    logic [7:0]        r_pix_data;
    logic              r_pix_valid;
    logic              r_pix_last;
    logic              r_busy;
    logic              r_done;

    logic              w_hs;
    logic              w_last_col;
    logic              w_final;
    logic              w_nxt_border;
    logic              w_nxt_final;
    logic [RW-1:0]     w_nxt_row;
    logic [CW-1:0]     w_nxt_col;
    logic [ADDR_W-1:0] w_row_a, w_col_a, w_nxt_row_a, w_nxt_col_a;

    function automatic logic [ADDR_W-1:0] f_addr(input logic [ADDR_W-1:0] row,
                                                 input logic [ADDR_W-1:0] col);
        return row * A_COLS + col;
    endfunction

    always_comb begin
        w_hs         = r_pix_valid & bus.pix_ready;
        w_last_col   = (r_col == COL_LAST);
        w_final      = (r_row == ROW_LAST) && w_last_col;
        w_nxt_col    = w_last_col ? '0 : r_col + COL_ONE;
        w_nxt_row    = w_last_col ? r_row + ROW_ONE : r_row;
        w_nxt_border = (w_nxt_row == '0) || (w_nxt_row == ROW_LAST) ||
                       (w_nxt_col == '0) || (w_nxt_col == COL_LAST);
        w_nxt_final  = (w_nxt_row == ROW_LAST) && (w_nxt_col == COL_LAST);
        w_row_a      = ADDR_W'(r_row);
        w_col_a      = ADDR_W'(r_col);
        w_nxt_row_a  = ADDR_W'(w_nxt_row);
        w_nxt_col_a  = ADDR_W'(w_nxt_col);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_pcnt      <= '0;
            r_mem_rd    <= 1'b0;
            r_rd_top    <= 1'b0;
            r_mem_addr  <= '0;
            r_ret_top   <= 1'b0;
            r_ret_bot   <= 1'b0;
            r_stage     <= '0;
            r_z1        <= '0;
            r_z2        <= '0;
            r_z3        <= '0;
            r_z4        <= '0;
            r_z5        <= '0;
            r_z6        <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Read data lands one cycle after the strobe; tag it top/bottom.
            r_ret_top <= r_mem_rd & r_rd_top;
            r_ret_bot <= r_mem_rd & ~r_rd_top;
            if (r_ret_top) begin
                r_stage <= bus.mem_rdata;
            end
            // The window only moves once both halves of a column are in hand.
            if (r_ret_bot) begin
                r_z1 <= r_z2;
                r_z2 <= r_z3;
                r_z3 <= r_stage;
                r_z4 <= r_z5;
                r_z5 <= r_z6;
                r_z6 <= bus.mem_rdata;
            end
            r_done   <= 1'b0;
            r_mem_rd <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row       <= '0;
                        r_col       <= '0;
                        r_busy      <= 1'b1;
                        r_pix_data  <= '0;
                        r_pix_valid <= 1'b1;
                        r_pix_last  <= 1'b0;
                        r_state     <= S_BORDER;
                    end
                end
                S_BORDER, S_OUT: begin
                    if (w_hs) begin
                        if (w_final) begin
                            r_pix_valid <= 1'b0;
                            r_pix_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_row      <= w_nxt_row;
                            r_col      <= w_nxt_col;
                            r_pix_last <= w_nxt_final;
                            if (w_nxt_border) begin
                                r_pix_data  <= '0;
                                r_pix_valid <= 1'b1;
                                r_state     <= S_BORDER;
                            end else begin
                                r_pix_valid <= 1'b0;
                                r_mem_rd    <= 1'b1;
                                r_rd_top    <= 1'b1;
                                r_pcnt      <= '0;
                                if (w_nxt_col == COL_ONE) begin
                                    r_mem_addr <= f_addr(w_nxt_row_a - A_ONE, ADDR_W'(0));
                                    r_state    <= S_PRIME;
                                end else begin
                                    r_mem_addr <= f_addr(w_nxt_row_a - A_ONE, w_nxt_col_a + A_ONE);
                                    r_state    <= S_FETCH_T;
                                end
                            end
                        end
                    end
                end
                S_PRIME: begin
                    // Prime order: top c0, bottom c0, top c1, bottom c1.
                    r_mem_rd <= 1'b1;
                    if (r_pcnt == 2'd3) begin
                        r_rd_top   <= 1'b1;
                        r_mem_addr <= f_addr(w_row_a - A_ONE, w_col_a + A_ONE);
                        r_state    <= S_FETCH_T;
                    end else begin
                        r_pcnt     <= r_pcnt + 2'd1;
                        r_rd_top   <= r_pcnt[0];
                        r_mem_addr <= f_addr(r_pcnt[0] ? w_row_a - A_ONE : w_row_a + A_ONE,
                                             (r_pcnt == 2'd0) ? ADDR_W'(0) : A_ONE);
                    end
                end
                S_FETCH_T: begin
                    r_mem_rd   <= 1'b1;
                    r_rd_top   <= 1'b0;
                    r_mem_addr <= f_addr(w_row_a + A_ONE, w_col_a + A_ONE);
                    r_state    <= S_FETCH_B;
                end
                S_FETCH_B: begin
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    // First cycle the bottom datum is still arriving; capture on the next.
                    if (!r_ret_bot) begin
                        r_pix_data  <= bus.z_out;
                        r_pix_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.z1        = r_z1;
    assign bus.z2        = r_z2;
    assign bus.z3        = r_z3;
    assign bus.z4        = r_z4;
    assign bus.z5        = r_z5;
    assign bus.z6        = r_z6;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_last  = r_pix_last;
    assign busy          = r_busy;
    assign done          = r_done;
endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Bench for sobel_scan_ctrl: a 4x5 instance exercised from a vector table and
// hand-written sequences, plus a 3x3 instance with a fixed ramp image.
module tb_sobel_scan_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start4 = 1'b0;
    logic start3 = 1'b0;
    logic busy4, done4, busy3, done3;

    sobel_scan_ctrl_if #(.ADDR_W(8)) b4 ();
    sobel_scan_ctrl_if #(.ADDR_W(4)) b3 ();

    sobel_scan_ctrl #(.ROWS(4), .COLS(5), .ADDR_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4), .bus(b4.master));
    sobel_scan_ctrl #(.ROWS(3), .COLS(3), .ADDR_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3), .bus(b3.master));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        int pat;
        int rmode;
        int exp_hs;
        int exp_rd;
    } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       sb4[$];
    exp_t       sb3[$];
    int         addr_log[$];
    logic [7:0] mem4 [0:255];
    logic [7:0] mem3 [0:15];
    logic [7:0] exp3 [0:8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
    int         hs4 = 0, done_cnt4 = 0, hs3 = 0, done_cnt3 = 0, reads3 = 0;
    logic       stall_hold = 1'b0;
    logic [7:0] stall_data = 8'h00;
    int         rdy_mode = 0;
    int         rdy_cyc = 0;

    // Vertical-gradient detector model: |bottom - top| with 1-2-1 weights, saturated.
    function automatic logic [7:0] det(input logic [7:0] a1, a2, a3, a4, a5, a6);
        int t, b, g;
        t = int'(a1) + 2 * int'(a2) + int'(a3);
        b = int'(a4) + 2 * int'(a5) + int'(a6);
        g = (b > t) ? b - t : t - b;
        if (g > 255) g = 255;
        return 8'(g);
    endfunction

    assign b4.z_out = det(b4.z1, b4.z2, b4.z3, b4.z4, b4.z5, b4.z6);
    assign b3.z_out = det(b3.z1, b3.z2, b3.z3, b3.z4, b3.z5, b3.z6);

    always @(posedge clk) begin
        if (b4.mem_rd) b4.mem_rdata <= mem4[b4.mem_addr];
        if (b3.mem_rd) b3.mem_rdata <= mem3[b3.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int r, input int c);
        if (r == 0 || r == 3 || c == 0 || c == 4) return 8'h00;
        return det(mem4[(r-1)*5+c-1], mem4[(r-1)*5+c], mem4[(r-1)*5+c+1],
                   mem4[(r+1)*5+c-1], mem4[(r+1)*5+c], mem4[(r+1)*5+c+1]);
    endfunction

    // Monitor for the 4x5 instance.
    always @(negedge clk) begin
        if (!reset) begin
            stall_hold = 1'b0;
            chk("rst_valid", 32'(b4.pix_valid), 0);
            chk("rst_busy", 32'(busy4), 0);
            chk("rst_done", 32'(done4), 0);
            chk("rst_mem_rd", 32'(b4.mem_rd), 0);
            chk("rst_addr", 32'(b4.mem_addr), 0);
            chk("rst_data", 32'(b4.pix_data), 0);
            chk("rst_last", 32'(b4.pix_last), 0);
            chk("rst_z", 32'(b4.z1 | b4.z2 | b4.z3 | b4.z4 | b4.z5 | b4.z6), 0);
        end else begin
            if (b4.mem_rd) addr_log.push_back(int'(b4.mem_addr));
            if (done4) done_cnt4++;
            if (stall_hold) begin
                chk("stall_valid", 32'(b4.pix_valid), 1);
                chk("stall_data", 32'(b4.pix_data), 32'(stall_data));
            end
            if (b4.pix_valid && b4.pix_ready) begin
                exp_t e;
                hs4++;
                if (sb4.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb4_underflow: got handshake data %0h expected none", b4.pix_data);
                end else begin
                    e = sb4.pop_front();
                    chk("pix_data", 32'(b4.pix_data), 32'(e.data));
                    chk("pix_last", 32'(b4.pix_last), 32'(e.last));
                end
            end
            stall_hold = b4.pix_valid && !b4.pix_ready;
            stall_data = b4.pix_data;
        end
    end

    // Monitor for the 3x3 instance.
    always @(negedge clk) begin
        if (reset) begin
            if (b3.mem_rd) reads3++;
            if (done3) done_cnt3++;
            if (b3.pix_valid && b3.pix_ready) begin
                exp_t e;
                hs3++;
                if (sb3.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb3_underflow: got handshake data %0h expected none", b3.pix_data);
                end else begin
                    e = sb3.pop_front();
                    chk("pix3_data", 32'(b3.pix_data), 32'(e.data));
                    chk("pix3_last", 32'(b3.pix_last), 32'(e.last));
                end
            end
        end
    end

    // Downstream ready pattern for the 4x5 stream.
    initial begin
        b4.pix_ready = 1'b1;
        b3.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rdy_cyc++;
            case (rdy_mode)
                0:       b4.pix_ready = 1'b1;
                1:       b4.pix_ready = (rdy_cyc % 3 == 0);
                default: b4.pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic fill_mem4(input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0:       mem4[i] = 8'hFF;
                1:       mem4[i] = 8'($urandom_range(0, 255));
                default: mem4[i] = 8'(i * 37 + 11);
            endcase
        end
    endtask

    task automatic push_frame4();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                sb4.push_back('{data: exp_pix(r, c), last: (r == 3 && c == 4)});
    endtask

    task automatic start_frame4();
        hs4 = 0;
        done_cnt4 = 0;
        addr_log.delete();
        push_frame4();
        @(posedge clk);
        #1 start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        chk("busy_after_start", 32'(busy4), 1);
    endtask

    task automatic wait_done4(input int max_cyc);
        int n;
        n = 0;
        while (done4 !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (done4 !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done4_timeout: got no done after %0d cycles expected done", max_cyc);
        end
    endtask

    task automatic check_addrs4(input int exp_rd);
        int k;
        k = 0;
        chk("rd_count", 32'(addr_log.size()), 32'(exp_rd));
        for (int r = 1; r <= 2; r++)
            for (int c = 0; c < 5; c++)
                for (int t = 0; t < 2; t++) begin
                    if (k < addr_log.size())
                        chk("rd_addr", 32'(addr_log[k]), 32'(((t == 0) ? r - 1 : r + 1) * 5 + c));
                    k++;
                end
    endtask

    task automatic finish_frame4(input int exp_hs, input int exp_rd);
        wait_done4(3000);
        repeat (3) @(negedge clk);
        chk("hs_count", 32'(hs4), 32'(exp_hs));
        chk("done_count", 32'(done_cnt4), 1);
        chk("sb4_left", 32'(sb4.size()), 0);
        chk("busy_end", 32'(busy4), 0);
        check_addrs4(exp_rd);
    endtask

    initial begin
        vec_t vecs[5];
        int   n;
        vecs[0] = '{pat: 0, rmode: 0, exp_hs: 20, exp_rd: 20};
        vecs[1] = '{pat: 0, rmode: 1, exp_hs: 20, exp_rd: 20};
        vecs[2] = '{pat: 1, rmode: 0, exp_hs: 20, exp_rd: 20};
        vecs[3] = '{pat: 1, rmode: 1, exp_hs: 20, exp_rd: 20};
        vecs[4] = '{pat: 2, rmode: 2, exp_hs: 20, exp_rd: 20};

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy4), 0);
        chk("idle_valid", 32'(b4.pix_valid), 0);
        chk("idle_done", 32'(done4), 0);
        chk("idle_addr", 32'(b4.mem_addr), 0);

        // 3x3 ramp image: only the centre is interior.
        for (int i = 0; i < 16; i++) mem3[i] = 8'(i);
        for (int i = 0; i < 9; i++) sb3.push_back('{data: exp3[i], last: (i == 8)});
        @(posedge clk);
        #1 start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        chk("busy3_after_start", 32'(busy3), 1);
        n = 0;
        while (done3 !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (done3 !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done3_timeout: got no done expected done");
        end
        repeat (3) @(negedge clk);
        chk("hs3_count", 32'(hs3), 9);
        chk("done3_count", 32'(done_cnt3), 1);
        chk("reads3", 32'(reads3), 6);
        chk("sb3_left", 32'(sb3.size()), 0);

        // Table-driven frames on the 4x5 instance.
        for (int v = 0; v < 5; v++) begin
            fill_mem4(vecs[v].pat);
            rdy_mode = vecs[v].rmode;
            start_frame4();
            finish_frame4(vecs[v].exp_hs, vecs[v].exp_rd);
        end

        // Reset in row 2, then a clean frame from the same image.
        rdy_mode = 0;
        fill_mem4(1);
        start_frame4();
        n = 0;
        while (hs4 < 11 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_row2", 32'(hs4 >= 11), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        sb4.delete();
        #1;
        chk("async_rst_valid", 32'(b4.pix_valid), 0);
        chk("async_rst_busy", 32'(busy4), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        start_frame4();
        finish_frame4(20, 20);

        // Start while busy is ignored; start right after done is accepted.
        rdy_mode = 1;
        fill_mem4(2);
        start_frame4();
        repeat (5) @(posedge clk);
        #1 start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        wait_done4(3000);
        chk("b2b_hs1", 32'(hs4), 20);
        chk("b2b_sb1", 32'(sb4.size()), 0);
        chk("b2b_rd1", 32'(addr_log.size()), 20);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_done1", 32'(done_cnt4), 1);
        chk("b2b_idle_busy", 32'(busy4), 0);
        hs4 = 0;
        done_cnt4 = 0;
        addr_log.delete();
        push_frame4();
        @(posedge clk);
        #1 start4 = 1'b0;
        chk("b2b_busy2", 32'(busy4), 1);
        finish_frame4(20, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_scan_ctrl.md
Name: sobel_scan_ctrl

Overview:
- Frame sequencer for the sobel3x3det datapath.
- On start it walks a ROWS x COLS 8-bit image held in a synchronous-read pixel memory, builds the six-pixel window (z1..z6) for each interior pixel, and captures the detector's z_out.
- Emits one result per pixel in raster order over a valid/ready stream to the edge-image writer. Border pixels are emitted as 0.

Parameters:
ROWS, 436, image height in pixels (min 3)
COLS, 576, image width in pixels (min 3)
ADDR_W, 18, pixel memory address width; must satisfy 2^ADDR_W >= ROWS*COLS

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a frame; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last pixel handshake
mem_rd  output  1  pixel memory read strobe
mem_addr  output  ADDR_W  read address = row*COLS + col
mem_rdata  input  8  read data, valid exactly one cycle after mem_rd
z1..z6  output  8 each  window to sobel3x3det: z1,z2,z3 = row r-1, cols c-1,c,c+1; z4,z5,z6 = row r+1, same cols
z_out  input  8  sobel3x3det result, combinational from z1..z6
pix_data  output  8  result pixel
pix_valid  output  1  pix_data valid; held until accepted
pix_ready  input  1  downstream accepts when pix_valid && pix_ready
pix_last  output  1  high with the final pixel (ROWS-1, COLS-1)

Behaviour:
- Reset (reset=0, any cycle, including mid-frame): state IDLE, row/col counters 0, z1..z6 = 0, pix_data = 0, pix_valid = pix_last = busy = done = mem_rd = 0, mem_addr = 0. The frame is abandoned; no partial output resumes.
- States: IDLE, BORDER, PRIME, FETCH_T, FETCH_B, SETTLE, OUT, DONE.
- IDLE: start=1 loads row=0, col=0 and moves to BORDER. start is ignored in every other state.
- BORDER (row 0, row ROWS-1, col 0, col COLS-1): pix_data=0, pix_valid=1. Hold until the handshake, then advance. No memory reads.
- Advance: col++. At col==COLS-1 wrap to col=0, row++. On the final pixel, pix_last=1; after its handshake go to DONE.
- Interior row entry (col becomes 1 on rows 1..ROWS-2): PRIME issues 4 reads in 4 consecutive cycles: (r-1,0), (r+1,0), (r-1,1), (r+1,1). Each returned pair is shifted into the window.
- FETCH_T / FETCH_B: read (r-1,c+1) then (r+1,c+1).
- Window shift happens when the bottom datum returns: z1<=z2, z2<=z3, z3<=top; z4<=z5, z5<=z6, z6<=bottom. The top datum is held in a staging register until then. z outputs change only on shifts.
- SETTLE: one cycle, so z_out reflects the stable window. Capture pix_data<=z_out and go to OUT.
- OUT: pix_valid=1 and pix_data stable until the handshake. Then advance: the next interior column goes to FETCH_T (no re-prime); col==COLS-1 goes to BORDER.
- Reads are issued only while no pixel is pending. Backpressure therefore never loses read data.
- Interior pixel cost: 2 read + 1 data-return + 1 settle + ≥1 output cycle. First interior pixel of a row adds the 4-cycle prime.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A new start is accepted in the following IDLE cycle.
- pix_valid never drops without a handshake; pix_data never changes while pix_valid && !pix_ready.
- Counters are sized $clog2(ROWS), $clog2(COLS). Address arithmetic is done at ADDR_W without truncation.

Test Plan:
- ROWS=3, COLS=3, memory = 0x00..0x08 raster, pix_ready=1 → 9 outputs, 8 zeros and center = sobel3x3det(0x00,0x01,0x02,0x06,0x07,0x08); pix_last on output 9; done pulse once.
- ROWS=4, COLS=5, memory all 0xFF → every interior output equals z_out for a constant window (0x00 for a correct detector); row 0, row 3, col 0 and col 4 all 0; exactly 20 handshakes.
- Same frame with pix_ready toggled 1-of-3 cycles → pix_data stable while stalled; output sequence identical to the unstalled run; no extra mem_rd.
- Monitor mem_addr on ROWS=4, COLS=5 → first interior row reads 0,10,1,11,2,12,3,13,4,14 in order; each address is read once per row.
- Assert reset low mid-frame (row 2), then release and start again → all outputs 0 during reset; second frame output is bit-identical to a clean run.
- start pulsed while busy → ignored, no restart; start in the cycle after done → a second full frame is produced.
